// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_pkg
//  Description : Shared types and constants for the IF/MEM shared-SRAM
//                arbiter. It holds the arbiter FSM state encoding, the
//                grant-owner type, the default SRAM wait-state count and
//                the width of the wait-state counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEM_ACC = 2'd1,
        IF_ACC  = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    // Owner of the access in flight
    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } gnt_t;

    // SRAM cycles per access (legal range 1..15)
    localparam int c_default_wait_cycles = 3;

    // Wide enough to hold WAIT_CYCLES-1 over the whole legal range
    localparam int c_wait_cnt_w = 4;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Bundle of the IF request port, the MEM request port and
//                the external SRAM pins served by mem_port_arbiter.
//                slave  - the arbiter side
//                master - the pipeline / SRAM side (testbench, pipeline top)
//  Signals     : if_req/if_addr/if_rdata/if_ready        instruction fetch
//                mem_r_en/mem_w_en/mem_addr/mem_wdata/
//                mem_rdata/mem_ready                     load/store
//                sram_addr/sram_wdata/sram_rdata/
//                sram_ce_n/sram_we_n/sram_oe_n           SRAM pins
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SRAM_AW = 16
);
    logic               if_req;
    logic [ADDR_W-1:0]  if_addr;
    logic [DATA_W-1:0]  if_rdata;
    logic               if_ready;

    logic               mem_r_en;
    logic               mem_w_en;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  mem_rdata;
    logic               mem_ready;

    logic [SRAM_AW-1:0] sram_addr;
    logic [DATA_W-1:0]  sram_wdata;
    logic [DATA_W-1:0]  sram_rdata;
    logic               sram_ce_n;
    logic               sram_we_n;
    logic               sram_oe_n;

    modport slave (
        input  if_req, if_addr, mem_r_en, mem_w_en, mem_addr, mem_wdata, sram_rdata,
        output if_rdata, if_ready, mem_rdata, mem_ready,
               sram_addr, sram_wdata, sram_ce_n, sram_we_n, sram_oe_n
    );

    modport master (
        output if_req, if_addr, mem_r_en, mem_w_en, mem_addr, mem_wdata, sram_rdata,
        input  if_rdata, if_ready, mem_rdata, mem_ready,
               sram_addr, sram_wdata, sram_ce_n, sram_we_n, sram_oe_n
    );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_wait_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wait_counter
//  Description : Loadable down-counter with terminal-count flag. A load
//                takes priority over counting. The counter stops at zero,
//                so tc stays high until the next load.
//  Ports       : clk, rst (async, active-low)
//                load / load_val  start a new count
//                en               decrement while nonzero
//                count            current value
//                tc               count == 0
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wait_counter #(
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_val,
    input  wire logic             en,
    output logic      [WIDTH-1:0] count,
    output logic                  tc
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - c_one;
        end
    end

    assign count = r_count;
    assign tc    = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-ported, multi-cycle SRAM between
//                instruction fetch and the MEM stage. A MEM request wins
//                over an IF request. Each access holds the SRAM enables for
//                WAIT_CYCLES cycles, then spends one cycle in DONE. The
//                ready pulse is registered out of DONE, so it appears in
//                the IDLE cycle that follows. The freeze outputs stall the
//                pipeline while its request is still outstanding.
//  Ports       : clk, rst (async, active-low)
//                bus          mem_port_arbiter_if.slave (IF, MEM, SRAM)
//                freeze_if    hold PC and IF/ID
//                freeze_pipe  hold all pipeline registers
//                busy         FSM not in IDLE
//                perf_if_stall / perf_mem_stall  (MEM_ARB_PERF_EN only)
//  Options     : `define MEM_ARB_PERF_EN adds saturating 32-bit stall
//                counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int SRAM_AW     = 16,
    parameter int WAIT_CYCLES = c_default_wait_cycles   // 1..15
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mem_port_arbiter_if.slave  bus,
    output logic               freeze_if,
    output logic               freeze_pipe,
    output logic               busy
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]        perf_if_stall,
    output logic [31:0]        perf_mem_stall
`endif
);

    localparam logic [c_wait_cnt_w-1:0] c_load_val = c_wait_cnt_w'(WAIT_CYCLES - 1);

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    gnt_t                 r_gnt;
    logic                 r_is_wr;
    logic [SRAM_AW-1:0]   r_sram_addr;
    logic [DATA_W-1:0]    r_sram_wdata;
    logic [DATA_W-1:0]    r_if_rdata;
    logic [DATA_W-1:0]    r_mem_rdata;
    logic                 r_if_ready;
    logic                 r_mem_ready;

    logic                 w_mem_req;
    logic                 w_ready_cycle;
    logic                 w_grant_mem;
    logic                 w_grant_if;
    logic                 w_in_acc;
    logic                 w_last;
    logic                 w_tc;
    logic [c_wait_cnt_w-1:0] w_cnt;
    logic                 w_ce_n;
    logic                 w_we_n;
    logic                 w_oe_n;

    // Simultaneous load/store enables count as one request and as a store.
    assign w_mem_req = bus.mem_r_en | bus.mem_w_en;

    // In the cycle a ready pulse is out, the requester still presents the
    // request it is about to retire. Granting then would repeat the access.
    assign w_ready_cycle = r_if_ready | r_mem_ready;

    // ------------------------------------------------------------------
    // Wait-state sequencing
    // ------------------------------------------------------------------
    mem_wait_counter #(
        .WIDTH    (c_wait_cnt_w)
    ) u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (w_grant_mem | w_grant_if),
        .load_val (c_load_val),
        .en       (w_in_acc),
        .count    (w_cnt),
        .tc       (w_tc)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_mem = 1'b0;
        w_grant_if  = 1'b0;
        w_in_acc    = 1'b0;
        w_ce_n      = 1'b1;
        w_we_n      = 1'b1;
        w_oe_n      = 1'b1;
        case (r_state)
            IDLE: begin
                if (!w_ready_cycle) begin
                    if (w_mem_req) begin
                        w_grant_mem = 1'b1;
                        w_state_nxt = MEM_ACC;
                    end else if (bus.if_req) begin
                        w_grant_if  = 1'b1;
                        w_state_nxt = IF_ACC;
                    end
                end
            end
            MEM_ACC, IF_ACC: begin
                w_in_acc = 1'b1;
                w_ce_n   = 1'b0;
                w_we_n   = ~r_is_wr;
                w_oe_n   = r_is_wr;
                if (w_tc) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_last = w_in_acc & w_tc;

    // ------------------------------------------------------------------
    // Request capture, read-data capture and ready pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gnt        <= GNT_IF;
            r_is_wr      <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
            r_if_rdata   <= '0;
            r_mem_rdata  <= '0;
            r_if_ready   <= 1'b0;
            r_mem_ready  <= 1'b0;
        end else begin
            if (w_grant_mem) begin
                r_gnt        <= GNT_MEM;
                r_is_wr      <= bus.mem_w_en;
                r_sram_addr  <= bus.mem_addr[SRAM_AW+1:2];
                r_sram_wdata <= bus.mem_wdata;
            end else if (w_grant_if) begin
                r_gnt        <= GNT_IF;
                r_is_wr      <= 1'b0;
                r_sram_addr  <= bus.if_addr[SRAM_AW+1:2];
            end

            if (w_last && !r_is_wr) begin
                if (r_gnt == GNT_MEM) begin
                    r_mem_rdata <= bus.sram_rdata;
                end else begin
                    r_if_rdata  <= bus.sram_rdata;
                end
            end

            r_mem_ready <= (r_state == DONE) && (r_gnt == GNT_MEM);
            r_if_ready  <= (r_state == DONE) && (r_gnt == GNT_IF);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.sram_addr  = r_sram_addr;
    assign bus.sram_wdata = r_sram_wdata;
    assign bus.sram_ce_n  = w_ce_n;
    assign bus.sram_we_n  = w_we_n;
    assign bus.sram_oe_n  = w_oe_n;
    assign bus.if_rdata   = r_if_rdata;
    assign bus.if_ready   = r_if_ready;
    assign bus.mem_rdata  = r_mem_rdata;
    assign bus.mem_ready  = r_mem_ready;

    // A pending MEM request freezes everything, including the cycles in
    // which IF owns the port.
    assign freeze_pipe = w_mem_req & ~r_mem_ready;
    assign freeze_if   = freeze_pipe | (bus.if_req & ~r_if_ready);
    assign busy        = (r_state != IDLE);

`ifdef MEM_ARB_PERF_EN
    logic [31:0] r_perf_if_stall;
    logic [31:0] r_perf_mem_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_if_stall  <= '0;
            r_perf_mem_stall <= '0;
        end else begin
            if (freeze_if && (r_perf_if_stall != '1)) begin
                r_perf_if_stall <= r_perf_if_stall + 32'd1;
            end
            if (freeze_pipe && (r_perf_mem_stall != '1)) begin
                r_perf_mem_stall <= r_perf_mem_stall + 32'd1;
            end
        end
    end

    assign perf_if_stall  = r_perf_if_stall;
    assign perf_mem_stall = r_perf_mem_stall;
`endif

    // Byte-lane bits and address bits above the SRAM range are ignored.
    // The live count is only needed inside the counter.
    logic w_unused_bits;
    assign w_unused_bits = ^{bus.mem_addr[ADDR_W-1:SRAM_AW+2], bus.mem_addr[1:0],
                             bus.if_addr[ADDR_W-1:SRAM_AW+2],  bus.if_addr[1:0],
                             w_cnt};

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter. It contains a
//                behavioural SRAM and a shadow memory that give the
//                expected read data. Latency, SRAM strobe counts and freeze
//                behaviour come from the access timing rules (grant cycle,
//                WAIT_CYCLES access cycles, DONE, then ready). The bench
//                runs directed scenarios and then random traffic.
//  Options     : `define MEM_ARB_PERF_EN also checks the stall counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int W = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32), .SRAM_AW(16)) bus ();

    logic freeze_if;
    logic freeze_pipe;
    logic busy;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_stall;
    logic [31:0] perf_mem_stall;
`endif

    mem_port_arbiter #(
        .ADDR_W        (32),
        .DATA_W        (32),
        .SRAM_AW       (16),
        .WAIT_CYCLES   (W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .freeze_if     (freeze_if),
        .freeze_pipe   (freeze_pipe),
        .busy          (busy)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_if_stall (perf_if_stall),
        .perf_mem_stall(perf_mem_stall)
`endif
    );

    // Behavioural SRAM (256 words) and the bench's shadow copy
    logic [31:0] sram_mem [0:255];
    logic [31:0] ref_mem  [0:255];

    assign bus.sram_rdata = (!bus.sram_ce_n && !bus.sram_oe_n) ?
                            sram_mem[bus.sram_addr[7:0]] : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (!bus.sram_ce_n && !bus.sram_we_n)
            sram_mem[bus.sram_addr[7:0]] <= bus.sram_wdata;
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_if_rdata  = 32'h0;
    logic [31:0] exp_mem_rdata = 32'h0;

    task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Address with random ignored bits; the SRAM word index is 'word'
    function automatic logic [31:0] mk_addr(input logic [7:0] word);
        logic [31:0] a;
        a = ($urandom & 32'hFFFC_0003) | ({24'h0, word} << 2);
        return a;
    endfunction

    task automatic wait_quiet();
        for (int i = 0; i < 40; i++) begin
            if (!busy && !bus.if_ready && !bus.mem_ready) break;
            @(negedge clk);
        end
        chk_val("quiet", {30'h0, busy, bus.if_ready | bus.mem_ready}, 32'h0);
    endtask

    // One transaction, issued from a quiet IDLE. Inputs are driven and
    // outputs sampled at the falling edge. The issue cycle is cycle 0.
    task automatic run_txn(input bit do_if, input bit do_mem, input bit mem_wr,
                           input bit mem_both, input logic [31:0] if_a,
                           input logic [31:0] mem_a, input logic [31:0] wd,
                           input int drop_at);
        bit mem_done, if_done, seen_m, seen_i;
        int mem_k, ce_cnt, we_cnt, oe_cnt, n_rd;
        logic [31:0] exp_if_word, exp_mem_word;

        wait_quiet();
        bus.if_req    = do_if;
        bus.if_addr   = if_a;
        bus.mem_r_en  = do_mem && (!mem_wr || mem_both);
        bus.mem_w_en  = do_mem && mem_wr;
        bus.mem_addr  = mem_a;
        bus.mem_wdata = wd;
        #1;
        chk_val("freeze_pipe_c0", {31'h0, freeze_pipe}, {31'h0, do_mem});
        chk_val("freeze_if_c0",   {31'h0, freeze_if},   {31'h0, do_if | do_mem});

        // MEM goes first, so a store is visible to an IF read of the same word
        if (do_mem && mem_wr) ref_mem[mem_a[9:2]] = wd;
        exp_mem_word = ref_mem[mem_a[9:2]];
        exp_if_word  = ref_mem[if_a[9:2]];

        mem_done = !do_mem; if_done = !do_if; seen_m = 0; seen_i = 0;
        mem_k = 0; ce_cnt = 0; we_cnt = 0; oe_cnt = 0;
        n_rd = (do_if ? 1 : 0) + ((do_mem && !mem_wr) ? 1 : 0);

        for (int k = 1; k <= 40 && !(mem_done && if_done); k++) begin
            @(negedge clk);
            if (!bus.sram_ce_n) begin
                ce_cnt++;
                if (!bus.sram_we_n) we_cnt++;
                if (!bus.sram_oe_n) oe_cnt++;
                if (!mem_done && !seen_m) begin
                    seen_m = 1;
                    chk_val("sram_addr_mem", {16'h0, bus.sram_addr}, {16'h0, mem_a[17:2]});
                    if (mem_wr) chk_val("sram_wdata", bus.sram_wdata, wd);
                end else if (mem_done && !seen_i) begin
                    seen_i = 1;
                    chk_val("sram_addr_if", {16'h0, bus.sram_addr}, {16'h0, if_a[17:2]});
                end
            end
            if (k < W + 2 && (bus.mem_r_en || bus.mem_w_en))
                chk_val("freeze_pipe", {31'h0, freeze_pipe}, 32'h1);
            if (k < W + 2 && (bus.mem_r_en || bus.mem_w_en || bus.if_req))
                chk_val("freeze_if", {31'h0, freeze_if}, 32'h1);
            if (bus.mem_ready) begin
                if (mem_done) begin
                    chk_val("mem_ready_extra", {31'h0, bus.mem_ready}, 32'h0);
                end else begin
                    mem_done = 1; mem_k = k;
                    chk_val("mem_latency", k, W + 2);
                    chk_val("freeze_pipe_rdy", {31'h0, freeze_pipe}, 32'h0);
                    if (!mem_wr) begin
                        exp_mem_rdata = exp_mem_word;
                        chk_val("mem_rdata", bus.mem_rdata, exp_mem_word);
                    end
                    bus.mem_r_en = 0; bus.mem_w_en = 0;
                end
            end
            if (bus.if_ready) begin
                if (if_done) begin
                    chk_val("if_ready_extra", {31'h0, bus.if_ready}, 32'h0);
                end else begin
                    if_done = 1;
                    if (do_mem)
                        chk_val("if_after_mem",
                                {31'h0, mem_done && k >= mem_k + W + 2 && k <= mem_k + W + 3}, 32'h1);
                    else
                        chk_val("if_latency", k, W + 2);
                    exp_if_rdata = exp_if_word;
                    chk_val("if_rdata", bus.if_rdata, exp_if_word);
                    bus.if_req = 0;
                end
            end
            if (k == drop_at) begin
                bus.mem_r_en = 0; bus.mem_w_en = 0;
            end
        end
        chk_val("mem_done", {31'h0, mem_done}, 32'h1);
        chk_val("if_done",  {31'h0, if_done},  32'h1);
        chk_val("ce_cycles", ce_cnt, W * ((do_if ? 1 : 0) + (do_mem ? 1 : 0)));
        chk_val("we_cycles", we_cnt, (do_mem && mem_wr) ? W : 0);
        chk_val("oe_cycles", oe_cnt, W * n_rd);

        // One cycle later: no repeated ready, no new access, rdata held
        bus.if_req = 0; bus.mem_r_en = 0; bus.mem_w_en = 0;
        @(negedge clk);
        chk_val("post_idle", {29'h0, busy, bus.if_ready, bus.mem_ready}, 32'h0);
        chk_val("hold_if_rdata",  bus.if_rdata,  exp_if_rdata);
        chk_val("hold_mem_rdata", bus.mem_rdata, exp_mem_rdata);
    endtask

    initial begin
        int rdy_cnt;
        logic [31:0] wd;
`ifdef MEM_ARB_PERF_EN
        logic [31:0] p_if0, p_mem0;
`endif
        for (int i = 0; i < 256; i++) begin
            sram_mem[i] = $urandom;
            ref_mem[i]  = sram_mem[i];
        end
        sram_mem[4] = 32'hDEAD_BEEF;
        ref_mem[4]  = 32'hDEAD_BEEF;

        // ---------------- reset with IF request pending ----------------
        rst = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0040;
        bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b0;
        bus.mem_addr = 32'h0; bus.mem_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk_val("rst_sram_ctl", {29'h0, bus.sram_ce_n, bus.sram_we_n, bus.sram_oe_n}, 32'h7);
        chk_val("rst_busy",     {31'h0, busy}, 32'h0);
        chk_val("rst_ready",    {30'h0, bus.if_ready, bus.mem_ready}, 32'h0);
        chk_val("rst_if_rdata", bus.if_rdata, 32'h0);
        chk_val("rst_mem_rdata", bus.mem_rdata, 32'h0);
        chk_val("rst_sram_addr", {16'h0, bus.sram_addr}, 32'h0);
        chk_val("rst_sram_wdata", bus.sram_wdata, 32'h0);
`ifdef MEM_ARB_PERF_EN
        chk_val("rst_perf_if",  perf_if_stall,  32'h0);
        chk_val("rst_perf_mem", perf_mem_stall, 32'h0);
`endif
        rst = 1'b1;
        run_txn(1, 0, 0, 0, 32'h0000_0040, 32'h0, 32'h0, 0);

        // ---------------- IF and MEM load together ----------------
        run_txn(1, 1, 0, 0, mk_addr(8'd77), 32'h0000_0010, 32'h0, 0);

        // ---------------- store then load back ----------------
        run_txn(0, 1, 1, 0, 32'h0, 32'h0000_0020, 32'h1234_5678, 0);
        run_txn(0, 1, 0, 0, 32'h0, 32'h0000_0020, 32'h0, 0);

        // ---------------- both enables high acts as a store ----------------
        run_txn(0, 1, 1, 1, 32'h0, mk_addr(8'd33), 32'hCAFE_F00D, 0);

        // ---------------- reset on the 2nd access cycle ----------------
        wait_quiet();
        bus.mem_r_en = 1'b1; bus.mem_addr = mk_addr(8'd12);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_val("mid_busy", {31'h0, busy}, 32'h1);
        rst = 1'b0;
        #1;
        chk_val("mid_rst_ctl",  {29'h0, bus.sram_ce_n, bus.sram_we_n, bus.sram_oe_n}, 32'h7);
        chk_val("mid_rst_busy", {31'h0, busy}, 32'h0);
        bus.mem_r_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_if_rdata = 32'h0; exp_mem_rdata = 32'h0;
        rdy_cnt = 0;
        for (int k = 0; k < W + 4; k++) begin
            @(negedge clk);
            if (bus.mem_ready || bus.if_ready) rdy_cnt++;
        end
        chk_val("mid_rst_no_ready", rdy_cnt, 0);
        chk_val("mid_rst_mem_rdata", bus.mem_rdata, 32'h0);
        run_txn(0, 1, 0, 0, 32'h0, mk_addr(8'd12), 32'h0, 0);

        // ---------------- load dropped mid-access ----------------
        run_txn(0, 1, 0, 0, 32'h0, mk_addr(8'd99), 32'h0, 2);

`ifdef MEM_ARB_PERF_EN
        // ---------------- stall counters over one load ----------------
        wait_quiet();
        p_if0 = perf_if_stall; p_mem0 = perf_mem_stall;
        run_txn(0, 1, 0, 0, 32'h0, mk_addr(8'd4), 32'h0, 0);
        chk_val("perf_mem_delta", perf_mem_stall - p_mem0, W + 2);
        chk_val("perf_if_delta",  perf_if_stall  - p_if0,  W + 2);
`endif

        // ---------------- random traffic ----------------
        for (int n = 0; n < 24; n++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            wd   = $urandom;
            case (kind)
                0: run_txn(0, 1, 0, 0, 32'h0, mk_addr(8'($urandom)), 32'h0, 0);
                1: run_txn(0, 1, 1, 0, 32'h0, mk_addr(8'($urandom)), wd, 0);
                2: run_txn(1, 0, 0, 0, mk_addr(8'($urandom)), 32'h0, 32'h0, 0);
                default: run_txn(1, 1, 1'($urandom), 0, mk_addr(8'($urandom)),
                                 mk_addr(8'($urandom)), wd, 0);
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
